// File: rtl/raisin64_mem_pkg.sv
// raisin64_mem_pkg: width encodings, responder states and per-width byte helpers
package raisin64_mem_pkg;
  typedef enum logic [1:0] {W64 = 2'd0, W32 = 2'd1, W16 = 2'd2, W8 = 2'd3} width_e;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;
  function automatic logic [3:0] width_bytes(width_e w);
    return w == W64 ? 4'd8 : w == W32 ? 4'd4 : w == W16 ? 4'd2 : 4'd1;
  endfunction
  function automatic logic [7:0] width_mask(width_e w);
    return w == W64 ? 8'hFF : w == W32 ? 8'h0F : w == W16 ? 8'h03 : 8'h01;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, lane-shifted write data and misalignment flag
module dmem_lane_align
  import raisin64_mem_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  width,
  input  logic [63:0] wdata,
  output logic [7:0]  be,
  output logic [63:0] data,
  output logic        misaligned
);
  logic [3:0] nb;
  assign nb = width_bytes(width_e'(width));
  assign be = width_mask(width_e'(width)) << off;
  assign data = wdata << {off, 3'b000};
  assign misaligned = |(off & nb[2:0] - 3'd1);
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: pipeline data-memory port to synchronous 64-bit SRAM bridge
module dmem_responder
  import raisin64_mem_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          cpu_addr,
  input  logic [63:0]          cpu_wdata,
  input  logic [1:0]           cpu_write_width,
  input  logic                 cpu_rstrobe,
  input  logic                 cpu_wstrobe,
  output logic [63:0]          cpu_rdata,
  output logic                 cpu_cycle_complete,
  output logic                 cpu_err,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [7:0]           sram_be,
  output logic [63:0]          sram_wdata,
  input  logic [63:0]          sram_rdata
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic rd_q, rd_d, err_q, err_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0] be_q, be_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0] al_be;
  logic [63:0] al_data;
  logic al_mis, oor, acc, done;
  dmem_lane_align u_align (
    .off(cpu_addr[2:0]),
    .width(cpu_write_width),
    .wdata(cpu_wdata),
    .be(al_be),
    .data(al_data),
    .misaligned(al_mis)
  );
  assign oor = |(cpu_addr >> ADDR_BITS);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    err_d = err_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (cpu_rstrobe || cpu_wstrobe) begin
        rd_d = cpu_rstrobe;
        err_d = (cpu_rstrobe && cpu_wstrobe) || oor || (cpu_wstrobe && al_mis);
        addr_d = {cpu_addr[ADDR_BITS-1:3], 3'b000};
        be_d = al_be;
        wdata_d = al_data;
        cnt_d = 4'd0;
        state_d = err_d ? DONE : ACCESS;
      end
      ACCESS: if (cnt_q == 4'(WAIT_STATES)) state_d = DONE; else cnt_d = cnt_q + 4'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      err_q <= err_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
    end
  assign acc = state_q == ACCESS;
  assign done = state_q == DONE;
  assign cpu_cycle_complete = done;
  assign cpu_err = done && err_q;
  assign cpu_rdata = (done && rd_q && !err_q) ? sram_rdata : '0;
  assign sram_cs = acc;
  assign sram_we = acc && !rd_q;
  assign sram_be = (acc && !rd_q) ? be_q : '0;
  assign sram_addr = addr_q;
  assign sram_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench with SRAM model for dmem_responder
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0;
  logic [1:0] cpu_write_width = '0;
  logic cpu_rstrobe = 1'b0, cpu_wstrobe = 1'b0;
  logic [63:0] cpu_rdata, sram_wdata;
  logic [63:0] sram_rdata = '0;
  logic cpu_cycle_complete, cpu_err, sram_cs, sram_we;
  logic [7:0] sram_addr, sram_be;
  logic [63:0] mem [0:31];
  int errors = 0, checks = 0;
  typedef struct {logic [63:0] rd; logic err; int lat;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  dmem_responder #(.WAIT_STATES(1), .ADDR_BITS(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_write_width(cpu_write_width),
    .cpu_rstrobe(cpu_rstrobe),
    .cpu_wstrobe(cpu_wstrobe),
    .cpu_rdata(cpu_rdata),
    .cpu_cycle_complete(cpu_cycle_complete),
    .cpu_err(cpu_err),
    .sram_cs(sram_cs),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_be(sram_be),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );
  always @(posedge clk)
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 8; b++)
          if (sram_be[b]) mem[sram_addr[7:3]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else sram_rdata <= mem[sram_addr[7:3]];
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic rd, input logic wr, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [1:0] w, input int exp_lat, input int exp_cs,
                      input logic [7:0] exp_be, input logic [63:0] exp_wd, input logic [63:0] exp_rd,
                      input logic exp_err, input logic pulse);
    int cs_n, comp_n;
    exp_t e;
    sb.push_back('{exp_rd, exp_err, exp_lat});
    @(posedge clk);
    #1;
    cpu_addr = addr;
    cpu_wdata = wdata;
    cpu_write_width = w;
    cpu_rstrobe = rd;
    cpu_wstrobe = wr;
    @(posedge clk);
    #1;
    cpu_rstrobe = 1'b0;
    cpu_wstrobe = 1'b0;
    cs_n = 0;
    comp_n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (pulse) cpu_rstrobe = (k == 1);
      if (sram_cs) begin
        cs_n++;
        chk({tag, " sram_addr"}, 64'(sram_addr), 64'(addr[7:0] & 8'hF8));
        chk({tag, " sram_we"}, 64'(sram_we), 64'(wr));
        chk({tag, " sram_be"}, 64'(sram_be), wr ? 64'(exp_be) : 64'd0);
        if (wr) chk({tag, " sram_wdata"}, sram_wdata, exp_wd);
      end
      if (cpu_cycle_complete) begin
        comp_n++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, " latency"}, 64'(k), 64'(e.lat));
          chk({tag, " rdata"}, cpu_rdata, e.rd);
          chk({tag, " err"}, 64'(cpu_err), 64'(e.err));
        end
      end else chk({tag, " idle_out"}, cpu_rdata | 64'(cpu_err), 64'd0);
    end
    chk({tag, " cs_cycles"}, 64'(cs_n), 64'(exp_cs));
    chk({tag, " completions"}, 64'(comp_n), 64'd1);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[1] = 64'hCAFEF00D12345678;
    mem[2] = 64'h1122334455667788;
    repeat (2) @(posedge clk);
    #1;
    chk("reset complete", 64'(cpu_cycle_complete), 64'd0);
    chk("reset sram_cs", 64'(sram_cs), 64'd0);
    chk("reset rdata", cpu_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer("rd10", 1, 0, 64'h10, 0, 0, 3, 2, 0, 0, 64'h1122334455667788, 0, 0);
    xfer("wr8_13", 0, 1, 64'h13, 64'hAB, 3, 3, 2, 8'h08, 64'h00000000AB000000, 0, 0, 0);
    xfer("rd10b", 1, 0, 64'h10, 0, 0, 3, 2, 0, 0, 64'h11223344AB667788, 0, 0);
    xfer("wr32_14", 0, 1, 64'h14, 64'hDEADBEEF, 1, 3, 2, 8'hF0, 64'hDEADBEEF00000000, 0, 0, 0);
    xfer("rd17", 1, 0, 64'h17, 0, 0, 3, 2, 0, 0, 64'hDEADBEEFAB667788, 0, 0);
    xfer("wr64_18", 0, 1, 64'h18, 64'h0123456789ABCDEF, 0, 3, 2, 8'hFF, 64'h0123456789ABCDEF, 0, 0, 0);
    xfer("rd1f", 1, 0, 64'h1F, 0, 0, 3, 2, 0, 0, 64'h0123456789ABCDEF, 0, 0);
    xfer("wr16_22", 0, 1, 64'h22, 64'hBEEF, 2, 3, 2, 8'h0C, 64'h00000000BEEF0000, 0, 0, 0);
    xfer("rd20", 1, 0, 64'h20, 0, 0, 3, 2, 0, 0, 64'h00000000BEEF0000, 0, 0);
    xfer("wr32_mis", 0, 1, 64'h06, 64'h55, 1, 1, 0, 0, 0, 0, 1, 0);
    xfer("rd_oor", 1, 0, 64'h100, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    xfer("wr_oor", 0, 1, 64'h1000, 64'h77, 3, 1, 0, 0, 0, 0, 1, 0);
    xfer("both", 1, 1, 64'h10, 64'h99, 3, 1, 0, 0, 0, 0, 1, 0);
    xfer("rd08_pulse", 1, 0, 64'h08, 0, 0, 3, 2, 0, 0, 64'hCAFEF00D12345678, 0, 1);
    @(posedge clk);
    #1;
    cpu_addr = 64'h10;
    cpu_rstrobe = 1'b1;
    @(posedge clk);
    #1;
    cpu_rstrobe = 1'b0;
    @(negedge clk);
    chk("abort cs first", 64'(sram_cs), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort cs drop", 64'(sram_cs), 64'd0);
    chk("abort we drop", 64'(sram_we), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort no complete", 64'(cpu_cycle_complete), 64'd0);
    end
    rst_n = 1'b1;
    xfer("rd_after_rst", 1, 0, 64'h10, 0, 0, 3, 2, 0, 0, 64'hDEADBEEFAB667788, 0, 0);
    chk("sb empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter: WAIT_STATES, default 1, extra SRAM access cycles per transfer (0..15).
REQ-002 SHALL have parameter: ADDR_BITS, default 8, byte-address width of the attached SRAM (256 bytes).
REQ-003 SHALL have a single clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cpu_addr  input  64  byte address from pipeline.
REQ-007 cpu_wdata  input  64  write data, right-justified.
REQ-008 cpu_write_width  input  2  0=64b, 1=32b, 2=16b, 3=8b.
REQ-009 cpu_rstrobe  input  1  read request.
REQ-010 cpu_wstrobe  input  1  write request.
REQ-011 cpu_rdata  output  64  read data, valid only while cpu_cycle_complete.
REQ-012 cpu_cycle_complete  output  1  one-cycle completion pulse.
REQ-013 cpu_err  output  1  error qualifier, valid only with cpu_cycle_complete.
REQ-014 sram_cs  output  1  SRAM chip select.
REQ-015 sram_we  output  1  SRAM write enable.
REQ-016 sram_addr  output  ADDR_BITS  doubleword-aligned SRAM address (bits 2:0 zero).
REQ-017 sram_be  output  8  per-byte write enables.
REQ-018 sram_wdata  output  64  lane-shifted write data.
REQ-019 sram_rdata  input  64  synchronous SRAM read data, valid the cycle after a read edge.

Function
REQ-020 SHALL implement states IDLE, ACCESS, DONE.
REQ-021 IDLE: strobe sampled high at edge N SHALL capture addr/wdata/width/direction and enter ACCESS; otherwise stay IDLE.
REQ-022 ACCESS SHALL assert sram_cs (plus sram_we for writes) for exactly WAIT_STATES+1 cycles, then enter DONE.
REQ-023 DONE SHALL last one cycle, assert cpu_cycle_complete, return to IDLE; complete occurs during cycle N+WAIT_STATES+2.
REQ-024 Reads SHALL return the full aligned doubleword containing cpu_addr in cpu_rdata; cpu_addr[2:0] ignored for reads.
REQ-025 Writes SHALL set sram_be to width-many bytes starting at byte cpu_addr[2:0], with sram_wdata = cpu_wdata shifted left by 8*cpu_addr[2:0].
REQ-026 Misaligned write (addr[2:0] not a multiple of the width size) SHALL perform no SRAM access, and SHALL go IDLE->DONE in one cycle with cpu_err=1.
REQ-027 Address with any bit at or above ADDR_BITS set SHALL perform no SRAM access, and SHALL complete with cpu_err=1 and cpu_rdata=0.
REQ-028 cpu_rstrobe and cpu_wstrobe high together in IDLE SHALL be treated as a protocol error: no access, complete with cpu_err=1.
REQ-029 Strobes arriving in ACCESS or DONE SHALL be ignored, not queued.
REQ-030 Outside DONE, cpu_rdata SHALL be 0 and cpu_err SHALL be 0; outside ACCESS, sram_cs, sram_we and sram_be SHALL be 0.
REQ-031 Write completion SHALL drive cpu_rdata=0.

Reset
REQ-032 rst_n low SHALL force state IDLE, the wait counter to 0, and all outputs to 0, asynchronously.
REQ-033 Reset asserted mid-ACCESS SHALL drop sram_cs and sram_we immediately; the aborted transfer SHALL never complete.

Structure
REQ-034 Package raisin64_mem_pkg SHALL hold the width encodings (W64, W32, W16, W8), the state enum, and byte-count per width.
REQ-035 Sub-module dmem_lane_align (combinational: addr[2:0], width, wdata -> be, shifted data, misaligned flag) SHALL be instantiated once.

Verification
REQ-036 WAIT_STATES=1: rstrobe, addr 0x10, SRAM holding 0x1122334455667788 -> sram_cs high 2 cycles; complete at N+3 with rdata 0x1122334455667788, err 0.
REQ-037 wstrobe, width=3, addr 0x13, wdata 0xAB -> sram_be=0x08, sram_wdata=0x00000000AB000000; complete with err 0.
REQ-038 wstrobe, width=1, addr 0x06 -> no sram_cs; complete at N+1 with err 1.
REQ-039 rstrobe, addr 0x100 (ADDR_BITS=8) -> no sram_cs; complete with err 1, rdata 0.
REQ-040 Both strobes high together -> error completion; a strobe pulsed during ACCESS -> exactly one completion.
REQ-041 rst_n low during the second ACCESS cycle -> sram_cs drops the same cycle, no cpu_cycle_complete; next rstrobe served normally.
